// File: rtl/cpu_pkg.sv
// Shared definitions for the operand dispatch path between register-file read and execute.
package cpu_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int N_UNITS_DEF = 4;

    typedef enum logic [1:0] {UNIT_ADD, UNIT_SUB, UNIT_MUL, UNIT_DIV} unit_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] rs1;
        logic [DATA_W_DEF-1:0] rs2;
    } operand_pair_t;

endpackage

// File: rtl/dispatch_slot.sv
// One-entry valid/ready holding register for a single functional unit.
module dispatch_slot
    import cpu_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CLEAR_IDLE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_i,
    input  logic              drain_i,
    input  logic [DATA_W-1:0] rs1_i,
    input  logic [DATA_W-1:0] rs2_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] rs1_o,
    output logic [DATA_W-1:0] rs2_o
);

    logic              v_q, v_d;
    logic [DATA_W-1:0] rs1_q, rs1_d;
    logic [DATA_W-1:0] rs2_q, rs2_d;

    // A fill wins over a same-edge drain so a streaming unit sustains one pair per cycle.
    always_comb begin
        v_d   = v_q;
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        if (fill_i) begin
            v_d   = 1'b1;
            rs1_d = rs1_i;
            rs2_d = rs2_i;
        end else if (v_q && drain_i) begin
            v_d = 1'b0;
            if (CLEAR_IDLE != 0) begin
                rs1_d = '0;
                rs2_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= 1'b0;
            rs1_q <= '0;
            rs2_q <= '0;
        end else begin
            v_q   <= v_d;
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
        end
    end

    assign valid_o = v_q;
    assign rs1_o   = rs1_q;
    assign rs2_o   = rs2_q;

endmodule

// File: rtl/operand_dispatch.sv
// Routes an operand pair into the holding slot of the selected functional unit,
// with independent valid/ready back-pressure per unit.
module operand_dispatch
    import cpu_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int N_UNITS    = N_UNITS_DEF,
    parameter int SEL_W      = 2,
    parameter int CLEAR_IDLE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [DATA_W-1:0]         in_rs1,
    input  logic [DATA_W-1:0]         in_rs2,
    output logic [N_UNITS-1:0]        unit_valid,
    input  logic [N_UNITS-1:0]        unit_ready,
    output logic [N_UNITS*DATA_W-1:0] unit_rs1,
    output logic [N_UNITS*DATA_W-1:0] unit_rs2,
    output logic                      bad_sel,
    output logic [15:0]               disp_cnt
);

    logic               in_range;
    logic               sel_ready;
    logic               accept;
    logic [N_UNITS-1:0] fill;
    logic               bad_sel_q, bad_sel_d;
    logic [15:0]        disp_cnt_q, disp_cnt_d;

    // Out-of-range selects match no unit, so they are always accepted and later dropped.
    always_comb begin
        in_range  = 1'b0;
        sel_ready = 1'b1;
        for (int i = 0; i < N_UNITS; i++) begin
            if (in_sel == SEL_W'(i)) begin
                in_range  = 1'b1;
                sel_ready = !unit_valid[i] || unit_ready[i];
            end
        end
    end

    assign in_ready = sel_ready;
    assign accept   = in_valid && sel_ready;

    always_comb begin
        for (int i = 0; i < N_UNITS; i++) begin
            fill[i] = accept && (in_sel == SEL_W'(i));
        end
    end

    always_comb begin
        bad_sel_d  = accept && !in_range;
        disp_cnt_d = disp_cnt_q;
        if (accept && in_range) begin
            disp_cnt_d = disp_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bad_sel_q  <= 1'b0;
            disp_cnt_q <= '0;
        end else begin
            bad_sel_q  <= bad_sel_d;
            disp_cnt_q <= disp_cnt_d;
        end
    end

    assign bad_sel  = bad_sel_q;
    assign disp_cnt = disp_cnt_q;

    for (genvar i = 0; i < N_UNITS; i++) begin : g_slot
        dispatch_slot #(
            .DATA_W     (DATA_W),
            .CLEAR_IDLE (CLEAR_IDLE)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .fill_i  (fill[i]),
            .drain_i (unit_ready[i]),
            .rs1_i   (in_rs1),
            .rs2_i   (in_rs2),
            .valid_o (unit_valid[i]),
            .rs1_o   (unit_rs1[i*DATA_W +: DATA_W]),
            .rs2_o   (unit_rs2[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_operand_dispatch.sv
// Bench for operand_dispatch: a 4-unit hold-data instance and a 3-unit clear-on-idle instance.
module tb_operand_dispatch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: 4 units, CLEAR_IDLE=0
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [1:0]  a_sel = '0;
    logic [15:0] a_rs1 = '0, a_rs2 = '0;
    logic [3:0]  a_uvalid;
    logic [3:0]  a_uready = '0;
    logic [63:0] a_urs1, a_urs2;
    logic        a_bad;
    logic [15:0] a_cnt;

    // Instance B: 3 units, CLEAR_IDLE=1
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [1:0]  b_sel = '0;
    logic [15:0] b_rs1 = '0, b_rs2 = '0;
    logic [2:0]  b_uvalid;
    logic [2:0]  b_uready = '0;
    logic [47:0] b_urs1, b_urs2;
    logic        b_bad;
    logic [15:0] b_cnt;

    int tests = 0;
    int fails = 0;

    operand_dispatch #(.DATA_W(16), .N_UNITS(4), .SEL_W(2), .CLEAR_IDLE(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_sel(a_sel),
        .in_rs1(a_rs1), .in_rs2(a_rs2), .unit_valid(a_uvalid), .unit_ready(a_uready),
        .unit_rs1(a_urs1), .unit_rs2(a_urs2), .bad_sel(a_bad), .disp_cnt(a_cnt)
    );

    operand_dispatch #(.DATA_W(16), .N_UNITS(3), .SEL_W(2), .CLEAR_IDLE(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_sel(b_sel),
        .in_rs1(b_rs1), .in_rs2(b_rs2), .unit_valid(b_uvalid), .unit_ready(b_uready),
        .unit_rs1(b_urs1), .unit_rs2(b_urs2), .bad_sel(b_bad), .disp_cnt(b_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests++; if (a_uvalid !== 4'b0000) begin fails++; $display("FAIL reset_a_uvalid got=%b exp=0000", a_uvalid); end
        tests++; if (a_cnt !== 16'd0) begin fails++; $display("FAIL reset_a_cnt got=%0d exp=0", a_cnt); end
        tests++; if (a_bad !== 1'b0) begin fails++; $display("FAIL reset_a_bad got=%b exp=0", a_bad); end
        tests++; if (a_urs1 !== 64'd0 || a_urs2 !== 64'd0) begin fails++; $display("FAIL reset_a_data got=%h/%h exp=0", a_urs1, a_urs2); end
        tests++; if (b_uvalid !== 3'b000 || b_cnt !== 16'd0 || b_bad !== 1'b0) begin fails++; $display("FAIL reset_b got v=%b c=%0d b=%b exp 0", b_uvalid, b_cnt, b_bad); end
        // Fill slot 2 under stall, then reset mid-operation
        a_uready = 4'b0000;
        a_sel = 2'd2; a_rs1 = 16'h0005; a_rs2 = 16'h0007; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        tests++; if (a_uvalid !== 4'b0100 || a_urs2[2*16 +: 16] !== 16'h0007) begin fails++; $display("FAIL reset_prefill got v=%b rs2=%h exp v=0100 rs2=0007", a_uvalid, a_urs2[2*16 +: 16]); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (a_uvalid !== 4'b0000 || a_cnt !== 16'd0 || a_urs2[2*16 +: 16] !== 16'h0000) begin fails++; $display("FAIL reset_mid got v=%b c=%0d rs2=%h exp v=0000 c=0 rs2=0000", a_uvalid, a_cnt, a_urs2[2*16 +: 16]); end
    endtask

    task automatic test_routing();
        a_uready = 4'b1111;
        a_sel = 2'd3; a_rs1 = 16'h1234; a_rs2 = 16'hABCD; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        tests++; if (a_uvalid !== 4'b1000) begin fails++; $display("FAIL route_uvalid got=%b exp=1000", a_uvalid); end
        tests++; if (a_urs2[3*16 +: 16] !== 16'hABCD || a_urs1[3*16 +: 16] !== 16'h1234) begin fails++; $display("FAIL route_data got=%h/%h exp=1234/abcd", a_urs1[3*16 +: 16], a_urs2[3*16 +: 16]); end
        tests++; if (a_cnt !== 16'd1) begin fails++; $display("FAIL route_cnt got=%0d exp=1", a_cnt); end
        step();
        tests++; if (a_uvalid !== 4'b0000) begin fails++; $display("FAIL route_drain got=%b exp=0000", a_uvalid); end
    endtask

    task automatic test_back_pressure();
        logic [15:0] c0;
        c0 = a_cnt;
        a_uready = 4'b0000;
        a_sel = 2'd2; a_rs2 = 16'h0001; a_valid = 1'b1;
        step();
        a_rs2 = 16'h0002;
        #1;
        tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL bp_stall_ready got=%b exp=0", a_ready); end
        step();
        tests++; if (a_uvalid[2] !== 1'b1 || a_urs2[2*16 +: 16] !== 16'h0001) begin fails++; $display("FAIL bp_hold got v=%b rs2=%h exp v=1 rs2=0001", a_uvalid[2], a_urs2[2*16 +: 16]); end
        a_uready = 4'b0100;
        #1;
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%b exp=1", a_ready); end
        step();
        a_valid = 1'b0;
        tests++; if (a_uvalid[2] !== 1'b1 || a_urs2[2*16 +: 16] !== 16'h0002) begin fails++; $display("FAIL bp_refill got v=%b rs2=%h exp v=1 rs2=0002", a_uvalid[2], a_urs2[2*16 +: 16]); end
        tests++; if (a_cnt !== c0 + 16'd2) begin fails++; $display("FAIL bp_cnt got=%0d exp=%0d", a_cnt, c0 + 16'd2); end
        step();
        tests++; if (a_uvalid[2] !== 1'b0 || a_urs2[2*16 +: 16] !== 16'h0002) begin fails++; $display("FAIL bp_drain_hold got v=%b rs2=%h exp v=0 rs2=0002", a_uvalid[2], a_urs2[2*16 +: 16]); end
    endtask

    task automatic test_independence();
        a_uready = 4'b0000;
        a_sel = 2'd3; a_rs2 = 16'h0099; a_valid = 1'b1;
        step();
        a_sel = 2'd0; a_rs2 = 16'h0042;
        #1;
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL indep_ready got=%b exp=1", a_ready); end
        step();
        a_valid = 1'b0;
        tests++; if (a_uvalid !== 4'b1001) begin fails++; $display("FAIL indep_uvalid got=%b exp=1001", a_uvalid); end
        tests++; if (a_urs2[0 +: 16] !== 16'h0042 || a_urs2[3*16 +: 16] !== 16'h0099) begin fails++; $display("FAIL indep_data got=%h/%h exp=0042/0099", a_urs2[0 +: 16], a_urs2[3*16 +: 16]); end
        a_uready = 4'b1111;
        step();
        a_uready = 4'b0000;
    endtask

    task automatic test_out_of_range();
        logic [15:0] c0;
        logic [2:0]  v0;
        b_uready = 3'b000;
        b_sel = 2'd0; b_rs1 = 16'h0011; b_valid = 1'b1;
        step();
        c0 = b_cnt; v0 = b_uvalid;
        b_sel = 2'd3;
        #1;
        tests++; if (b_ready !== 1'b1) begin fails++; $display("FAIL oor_ready got=%b exp=1", b_ready); end
        step();
        b_valid = 1'b0;
        tests++; if (b_bad !== 1'b1) begin fails++; $display("FAIL oor_bad_pulse got=%b exp=1", b_bad); end
        tests++; if (b_uvalid !== v0 || b_cnt !== c0) begin fails++; $display("FAIL oor_nochange got v=%b c=%0d exp v=%b c=%0d", b_uvalid, b_cnt, v0, c0); end
        step();
        tests++; if (b_bad !== 1'b0) begin fails++; $display("FAIL oor_bad_clear got=%b exp=0", b_bad); end
        tests++; if (b_urs1[0 +: 16] !== 16'h0011) begin fails++; $display("FAIL oor_slot0 got=%h exp=0011", b_urs1[0 +: 16]); end
    endtask

    // Random traffic on instance A against a slot-level reference model.
    task automatic test_random();
        logic        mv[4];
        logic [15:0] m1[4], m2[4];
        logic [15:0] mcnt;
        logic        mbad;
        logic        exp_ready, acc;
        logic [3:0]  ev;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin mv[i] = 1'b0; m1[i] = '0; m2[i] = '0; end
        mcnt = '0; mbad = 1'b0;
        for (int n = 0; n < 400; n++) begin
            a_valid  = 1'($urandom_range(0, 3) != 0);
            a_sel    = 2'($urandom);
            a_uready = 4'($urandom);
            a_rs1    = 16'($urandom);
            a_rs2    = 16'($urandom);
            #1;
            exp_ready = !mv[a_sel] || a_uready[a_sel];
            tests++; if (a_ready !== exp_ready) begin fails++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, a_ready, exp_ready); end
            acc = a_valid && exp_ready;
            for (int i = 0; i < 4; i++) begin
                if (acc && a_sel == 2'(i)) begin
                    mv[i] = 1'b1; m1[i] = a_rs1; m2[i] = a_rs2;
                end else if (a_uready[i]) begin
                    mv[i] = 1'b0;
                end
            end
            if (acc) mcnt = mcnt + 16'd1;
            step();
            for (int i = 0; i < 4; i++) ev[i] = mv[i];
            tests++; if (a_uvalid !== ev || a_cnt !== mcnt || a_bad !== mbad) begin fails++; $display("FAIL rand_state n=%0d got v=%b c=%0d b=%b exp v=%b c=%0d b=%b", n, a_uvalid, a_cnt, a_bad, ev, mcnt, mbad); end
            for (int i = 0; i < 4; i++) begin
                tests++; if (a_urs1[i*16 +: 16] !== m1[i] || a_urs2[i*16 +: 16] !== m2[i]) begin fails++; $display("FAIL rand_data n=%0d u=%0d got=%h/%h exp=%h/%h", n, i, a_urs1[i*16 +: 16], a_urs2[i*16 +: 16], m1[i], m2[i]); end
            end
        end
        a_valid = 1'b0;
        a_uready = 4'b0000;
    endtask

    task automatic test_back_to_back_wrap();
        int bad_ready, bad_valid;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bad_ready = 0; bad_valid = 0;
        b_uready = 3'b010;
        b_sel = 2'd1; b_rs1 = 16'h1357; b_rs2 = 16'h2468; b_valid = 1'b1;
        for (int n = 0; n < 65537; n++) begin
            #1;
            if (b_ready !== 1'b1) bad_ready++;
            step();
            if (b_uvalid !== 3'b010) bad_valid++;
        end
        b_valid = 1'b0;
        tests++; if (bad_ready != 0) begin fails++; $display("FAIL stream_ready stalls got=%0d exp=0", bad_ready); end
        tests++; if (bad_valid != 0) begin fails++; $display("FAIL stream_valid gaps got=%0d exp=0", bad_valid); end
        tests++; if (b_cnt !== 16'd1) begin fails++; $display("FAIL stream_wrap_cnt got=%0d exp=1", b_cnt); end
        step();
        tests++; if (b_uvalid !== 3'b000 || b_urs1[1*16 +: 16] !== 16'h0000 || b_urs2[1*16 +: 16] !== 16'h0000) begin fails++; $display("FAIL stream_clear_idle got v=%b rs=%h/%h exp v=000 rs=0000/0000", b_uvalid, b_urs1[1*16 +: 16], b_urs2[1*16 +: 16]); end
        b_uready = 3'b000;
    endtask

    initial begin
        test_reset();
        test_routing();
        test_back_pressure();
        test_independence();
        test_out_of_range();
        test_random();
        test_back_to_back_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
